// File: rtl/frontend_read_return.sv
// Read-return responder: buffers full lines from the backend and serializes them as BEATS-word bursts.
// Optional sticky overrun flag o_return_overflow, enabled by defining READ_RETURN_OVERFLOW_CHECK_EN.
//
// state | meaning
// IDLE  | nothing to send, outputs low
// SEND  | presenting beat[beat_cnt] of the head entry
module frontend_read_return #(
  parameter int WORD_WIDTH    = 64,
  parameter int BEATS         = 4,
  parameter int ID_WIDTH      = 4,
  parameter int CORE_ID_WIDTH = 2,
  parameter int DEPTH         = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  output logic                          o_frontend_receive_ready,
  input  logic                          i_returned_data_valid,
  input  logic [WORD_WIDTH*BEATS-1:0]   i_returned_data,
  input  logic [ID_WIDTH-1:0]           i_returned_request_id,
  input  logic [CORE_ID_WIDTH-1:0]      i_returned_core_id,
  input  logic                          i_interconnection_ready,
  output logic                          o_scheduler_request_valid,
  output logic [WORD_WIDTH-1:0]         o_scheduler_read_data,
  output logic                          o_scheduler_read_data_last,
  output logic [ID_WIDTH-1:0]           o_scheduler_request_ID,
  output logic [CORE_ID_WIDTH-1:0]      o_scheduler_core_id
`ifdef READ_RETURN_OVERFLOW_CHECK_EN
  ,
  output logic                          o_return_overflow
`endif
);

  localparam int LINE_W = WORD_WIDTH * BEATS;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BC_W   = $clog2(BEATS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [LINE_W-1:0]        line_mem [DEPTH];
  logic [ID_WIDTH-1:0]      id_mem   [DEPTH];
  logic [CORE_ID_WIDTH-1:0] core_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [BC_W-1:0]  beat_cnt;
  logic [0:0]       state;
  logic [0:0]       state_nxt;

  logic              push;
  logic              pop;
  logic              beat_hs;
  logic              last_beat;
  logic              sending;
  logic [LINE_W-1:0] head_line;
  logic [WORD_WIDTH-1:0] head_beat;

  // Ready decodes the registered count only, so a same-cycle pop never opens a full FIFO.
  assign o_frontend_receive_ready = (count != CNT_W'(DEPTH));

  assign push      = i_returned_data_valid && o_frontend_receive_ready;
  assign sending   = (state == ST_SEND);
  assign last_beat = (beat_cnt == BC_W'(BEATS - 1));
  assign beat_hs   = sending && i_interconnection_ready;
  assign pop       = beat_hs && last_beat;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      line_mem[wr_ptr] <= i_returned_data;
      id_mem[wr_ptr]   <= i_returned_request_id;
      core_mem[wr_ptr] <= i_returned_core_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // A waiting entry (including one pushed this cycle) follows with no bubble.
        if (pop && (count_nxt == '0)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (beat_hs) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  assign head_line = line_mem[rd_ptr];

  always_comb begin
    head_beat = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_cnt == BC_W'(k)) begin
        head_beat = head_line[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Outputs are gated by state so reset forces them to zero without touching storage.
  assign o_scheduler_request_valid  = sending;
  assign o_scheduler_read_data      = sending ? head_beat : '0;
  assign o_scheduler_read_data_last = sending && last_beat;
  assign o_scheduler_request_ID     = sending ? id_mem[rd_ptr] : '0;
  assign o_scheduler_core_id        = sending ? core_mem[rd_ptr] : '0;

`ifdef READ_RETURN_OVERFLOW_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_return_overflow <= 1'b0;
    end else if (i_returned_data_valid && !o_frontend_receive_ready) begin
      o_return_overflow <= 1'b1;
    end
  end
`else
  // Without the flag, lines offered while full are dropped silently.
`endif

endmodule

// File: tb/tb_frontend_read_return.sv
// Directed self-checking bench for frontend_read_return.
// Overflow flag checks are built only when READ_RETURN_OVERFLOW_CHECK_EN is defined.
module tb_frontend_read_return;

  localparam int W  = 64;
  localparam int B  = 4;
  localparam int IW = 4;
  localparam int CW = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_ready;
  logic          rx_valid;
  logic [W*B-1:0] rx_data;
  logic [IW-1:0] rx_id;
  logic [CW-1:0] rx_core;
  logic          ic_ready;
  logic          tx_valid;
  logic [W-1:0]  tx_data;
  logic          tx_last;
  logic [IW-1:0] tx_id;
  logic [CW-1:0] tx_core;
`ifdef READ_RETURN_OVERFLOW_CHECK_EN
  logic          ovf;
`endif

  int total = 0;
  int bad   = 0;

  frontend_read_return #(
    .WORD_WIDTH(W), .BEATS(B), .ID_WIDTH(IW), .CORE_ID_WIDTH(CW), .DEPTH(D)
  ) dut (
    .i_clk                      (clk),
    .i_rst_n                    (rst_n),
    .o_frontend_receive_ready   (rx_ready),
    .i_returned_data_valid      (rx_valid),
    .i_returned_data            (rx_data),
    .i_returned_request_id      (rx_id),
    .i_returned_core_id         (rx_core),
    .i_interconnection_ready    (ic_ready),
    .o_scheduler_request_valid  (tx_valid),
    .o_scheduler_read_data      (tx_data),
    .o_scheduler_read_data_last (tx_last),
    .o_scheduler_request_ID     (tx_id),
    .o_scheduler_core_id        (tx_core)
`ifdef READ_RETURN_OVERFLOW_CHECK_EN
    ,
    .o_return_overflow          (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Beat k of line "id": id*0x100 + 0x11*(k+1); id 0 gives 0x11,0x22,0x33,0x44.
  function automatic logic [W-1:0] beat_val(input int id, input int k);
    return W'(id * 256 + 17 * (k + 1));
  endfunction

  function automatic logic [W*B-1:0] mk_line(input int id);
    logic [W*B-1:0] l;
    l = '0;
    for (int k = 0; k < B; k++) l[k*W +: W] = beat_val(id, k);
    return l;
  endfunction

  task automatic push_one(input int id, input int data_id, input int core);
    rx_valid = 1'b1;
    rx_id    = IW'(id);
    rx_core  = CW'(core);
    rx_data  = mk_line(data_id);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b expected 1", rx_ready);
    end
    total++;
    if (tx_valid !== 1'b0 || tx_data !== '0 || tx_last !== 1'b0 || tx_id !== '0 || tx_core !== '0) begin
      bad++; $display("FAIL reset_outputs: got valid=%b data=%h last=%b id=%h core=%h expected all 0",
                      tx_valid, tx_data, tx_last, tx_id, tx_core);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic [W-1:0] exp_beat [4] = '{64'h11, 64'h22, 64'h33, 64'h44};
    ic_ready = 1'b1;
    push_one(5, 0, 2);
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) begin
      bad++; $display("FAIL single_latency: valid=%b expected 0 in push cycle", tx_valid);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== exp_beat[k] || tx_last !== (k == 3) ||
          tx_id !== 4'd5 || tx_core !== 2'd2) begin
        bad++; $display("FAIL single_beat%0d: got valid=%b data=%h last=%b id=%0d core=%0d expected 1 %h %b 5 2",
                        k, tx_valid, tx_data, tx_last, tx_id, tx_core, exp_beat[k], (k == 3));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) begin
      bad++; $display("FAIL single_idle: valid=%b expected 0", tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic       rdy   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] exp_d [7] = '{64'h11, 64'h22, 64'h33, 64'h33, 64'h33, 64'h33, 64'h44};
    ic_ready = 1'b1;
    push_one(5, 0, 2);
    @(posedge clk); #1;
    for (int c = 0; c < 7; c++) begin
      ic_ready = rdy[c];
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== exp_d[c] || tx_last !== (c == 6) || tx_id !== 4'd5) begin
        bad++; $display("FAIL bp_cycle%0d: got valid=%b data=%h last=%b id=%0d expected 1 %h %b 5",
                        c, tx_valid, tx_data, tx_last, tx_id, exp_d[c], (c == 6));
      end
      @(posedge clk); #1;
    end
    ic_ready = 1'b1;
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) begin
      bad++; $display("FAIL bp_idle: valid=%b expected 0", tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int li;
    int k;
    ic_ready = 1'b1;
    rx_valid = 1'b1; rx_id = 4'd1; rx_core = 2'd1; rx_data = mk_line(1);
    @(posedge clk); #1;
    rx_id = 4'd2; rx_core = 2'd3; rx_data = mk_line(2);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      li = b / 4;
      k  = b % 4;
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== beat_val(li + 1, k) || tx_last !== (k == 3) ||
          tx_id !== IW'(li + 1) || tx_core !== (li == 0 ? 2'd1 : 2'd3)) begin
        bad++; $display("FAIL b2b_beat%0d: got valid=%b data=%h last=%b id=%0d core=%0d expected id %0d data %h",
                        b, tx_valid, tx_data, tx_last, tx_id, tx_core, li + 1, beat_val(li + 1, k));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: valid=%b expected 0", tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full;
    int li;
    int k;
    ic_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(i + 1, i + 1, i);
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b0) begin
      bad++; $display("FAIL full_ready: got %b expected 0", rx_ready);
    end
    push_one(9, 9, 3);
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b0 || tx_id !== 4'd1) begin
      bad++; $display("FAIL full_drop: ready=%b head id=%0d expected 0 and 1", rx_ready, tx_id);
    end
    @(posedge clk); #1;
    ic_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      li = b / 4;
      k  = b % 4;
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== beat_val(li + 1, k) || tx_last !== (k == 3) ||
          tx_id !== IW'(li + 1) || tx_core !== CW'(li)) begin
        bad++; $display("FAIL full_drain%0d: got valid=%b data=%h last=%b id=%0d core=%0d expected id %0d core %0d",
                        b, tx_valid, tx_data, tx_last, tx_id, tx_core, li + 1, li);
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
        bad++; $display("FAIL full_no_extra%0d: valid=%b id=%0d ready=%b expected valid 0 ready 1",
                        c, tx_valid, tx_id, rx_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_simultaneous;
    int ids   [4] = '{11, 12, 13, 14};
    int cores [4] = '{2, 3, 0, 1};
    int li;
    int k;
    ic_ready = 1'b0;
    push_one(10, 10, 1);
    push_one(11, 11, 2);
    for (int b = 0; b < 4; b++) begin
      ic_ready = 1'b1;
      if (b == 3) begin
        rx_valid = 1'b1; rx_id = 4'd12; rx_core = 2'd3; rx_data = mk_line(12);
      end
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== beat_val(10, b) || tx_id !== 4'd10) begin
        bad++; $display("FAIL sim_first%0d: got valid=%b data=%h id=%0d expected 1 %h 10",
                        b, tx_valid, tx_data, tx_id, beat_val(10, b));
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    ic_ready = 1'b0;
    push_one(13, 13, 0);
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b1) begin
      bad++; $display("FAIL sim_count3: ready=%b expected 1", rx_ready);
    end
    push_one(14, 14, 1);
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b0) begin
      bad++; $display("FAIL sim_count4: ready=%b expected 0", rx_ready);
    end
    @(posedge clk); #1;
    ic_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      li = b / 4;
      k  = b % 4;
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== beat_val(ids[li], k) || tx_last !== (k == 3) ||
          tx_id !== IW'(ids[li]) || tx_core !== CW'(cores[li])) begin
        bad++; $display("FAIL sim_drain%0d: got valid=%b data=%h last=%b id=%0d core=%0d expected id %0d core %0d",
                        b, tx_valid, tx_data, tx_last, tx_id, tx_core, ids[li], cores[li]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) begin
      bad++; $display("FAIL sim_idle: valid=%b expected 0", tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midline;
    ic_ready = 1'b0;
    push_one(6, 6, 1);
    push_one(7, 7, 2);
    push_one(8, 8, 3);
    ic_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== beat_val(6, 2)) begin
      bad++; $display("FAIL rst_pre: valid=%b data=%h expected 1 %h", tx_valid, tx_data, beat_val(6, 2));
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || tx_data !== '0 || tx_id !== '0 || tx_core !== '0 || tx_last !== 1'b0) begin
      bad++; $display("FAIL rst_async: valid=%b ready=%b data=%h id=%0d core=%0d last=%b expected 0 1 0 0 0 0",
                      tx_valid, rx_ready, tx_data, tx_id, tx_core, tx_last);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
        bad++; $display("FAIL rst_discard%0d: valid=%b ready=%b expected 0 1", c, tx_valid, rx_ready);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef READ_RETURN_OVERFLOW_CHECK_EN
  task automatic test_overflow;
    @(negedge clk);
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_reset: got %b expected 0", ovf);
    end
    ic_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(i + 1, i + 1, i);
    @(negedge clk);
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_fill: got %b expected 0", ovf);
    end
    push_one(9, 9, 0);
    @(negedge clk);
    total++;
    if (ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_set: got %b expected 1", ovf);
    end
    @(posedge clk); #1;
    ic_ready = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (ovf !== 1'b1 || tx_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_sticky: ovf=%b valid=%b expected 1 0", ovf, tx_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clear: got %b expected 0", ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rx_valid = 1'b0;
    rx_data  = '0;
    rx_id    = '0;
    rx_core  = '0;
    ic_ready = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset;
    test_single;
    test_backpressure;
    test_back_to_back;
    test_full;
    test_simultaneous;
    test_reset_midline;
`ifdef READ_RETURN_OVERFLOW_CHECK_EN
    test_overflow;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
